// File: rtl/backstabber_pkg.sv
// Shared encodings for the backstabber snoop front end.
// State codes, control bit indices and CR response bit positions.
package backstabber_pkg;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_DECODE     = 4'd1;
    localparam logic [3:0] ST_DEVIL_WAIT = 4'd2;
    localparam logic [3:0] ST_CR_SEND    = 4'd3;
    localparam logic [3:0] ST_CD_SEND    = 4'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_ACF_LT   = 14;
    localparam int CTRL_ADDR_FLT = 15;

    localparam int CRRESP_DT = 0;

endpackage

// File: rtl/devil_snoop_filter.sv
// Snoop match logic: acsnoop compare plus address window.
// Window end is formed one bit wider than the address so it never wraps.
module devil_snoop_filter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_ADDR_WIDTH   = 44
) (
    input  logic                          i_en,
    input  logic                          i_acf_lt,
    input  logic                          i_addr_flt,
    input  logic [3:0]                    i_acsnoop,
    input  logic [3:0]                    i_acsnoop_ref,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_size,
    output logic                          o_match
);

    localparam int W = C_ACE_ADDR_WIDTH + 1;

    logic [W-1:0] addr_x;
    logic [W-1:0] lo_x;
    logic [W-1:0] hi_x;
    logic         snoop_ok;
    logic         addr_ok;

    // Combine both filters; a disabled filter always passes.
    always_comb begin
        addr_x   = {1'b0, i_acaddr};
        lo_x     = W'(i_base);
        hi_x     = W'(i_base) + W'(i_size);
        snoop_ok = !i_acf_lt || (i_acsnoop == i_acsnoop_ref);
        addr_ok  = !i_addr_flt || ((addr_x >= lo_x) && (addr_x < hi_x));
        o_match  = i_en && snoop_ok && addr_ok;
    end

endmodule

// File: rtl/devil_snoop_scheduler.sv
// ACE snoop front end: classify AC requests, run the devil FSM on hits,
// and return CR/CD with timeout and hit statistics.
module devil_snoop_scheduler
    import backstabber_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_CD_BEATS         = 4
) (
    input  logic                          ace_aclk,
    input  logic                          ace_aresetn,
    input  logic                          i_acvalid,
    output logic                          o_acready,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
    input  logic [3:0]                    i_acsnoop,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_timeout_reg,
    output logic                          o_devil_start,
    output logic                          o_devil_ack,
    input  logic                          i_devil_crvalid,
    input  logic [4:0]                    i_devil_crresp,
    input  logic                          i_devil_cdvalid,
    input  logic                          i_devil_cdlast,
    input  logic [C_ACE_DATA_WIDTH-1:0]   i_devil_rdata,
    output logic                          o_crvalid,
    output logic [4:0]                    o_crresp,
    input  logic                          i_crready,
    output logic                          o_cdvalid,
    output logic [C_ACE_DATA_WIDTH-1:0]   o_cddata,
    output logic                          o_cdlast,
    input  logic                          i_cdready,
    output logic [3:0]                    o_state,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_hit_count,
    output logic                          o_timeout_flag
);

    localparam int BW = (C_CD_BEATS > 1) ? $clog2(C_CD_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(C_CD_BEATS - 1);

    logic [3:0]                    state_q;
    logic [3:0]                    state_d;
    logic                          acready_q;
    logic [C_ACE_ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]                    snoop_q;
    logic [4:0]                    crresp_q;
    logic [C_ACE_DATA_WIDTH-1:0]   rdata_q;
    logic                          cr_got_q;
    logic                          cd_got_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] timer_q;
    logic [BW-1:0]                 beat_q;
    logic                          start_q;
    logic                          ack_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] hit_q;
    logic                          tflag_q;

    logic       match;
    logic       in_decode;
    logic       in_wait;
    logic       cr_now;
    logic [4:0] resp_now;
    logic       cd_now;
    logic       done;
    logic       tmo;
    logic       cd_last_hs;
    logic       unused_cfg;

    assign unused_cfg = ^{i_control_reg[C_S_AXI_DATA_WIDTH-1:16],
                          i_control_reg[13:1],
                          i_acsnoop_reg[C_S_AXI_DATA_WIDTH-1:4]};

    devil_snoop_filter #(
        .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .C_ACE_ADDR_WIDTH   (C_ACE_ADDR_WIDTH)
    ) u_filter (
        .i_en          (i_control_reg[CTRL_EN]),
        .i_acf_lt      (i_control_reg[CTRL_ACF_LT]),
        .i_addr_flt    (i_control_reg[CTRL_ADDR_FLT]),
        .i_acsnoop     (snoop_q),
        .i_acsnoop_ref (i_acsnoop_reg[3:0]),
        .i_acaddr      (addr_q),
        .i_base        (i_base_addr_reg),
        .i_size        (i_addr_size_reg),
        .o_match       (match)
    );

    // Devil result as seen this cycle, including same-cycle arrivals.
    always_comb begin
        in_decode  = (state_q == ST_DECODE);
        in_wait    = (state_q == ST_DEVIL_WAIT);
        cr_now     = cr_got_q || i_devil_crvalid;
        resp_now   = cr_got_q ? crresp_q : i_devil_crresp;
        cd_now     = cd_got_q || (i_devil_cdvalid && i_devil_cdlast);
        done       = in_wait && cr_now && (!resp_now[CRRESP_DT] || cd_now);
        tmo        = in_wait && (i_timeout_reg != '0) &&
                     (timer_q == i_timeout_reg);
        cd_last_hs = (state_q == ST_CD_SEND) && i_cdready &&
                     (beat_q == LAST_BEAT);
    end

    // Next-state selection for the snoop FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (i_acvalid && acready_q) state_d = ST_DECODE;
            ST_DECODE:
                state_d = match ? ST_DEVIL_WAIT : ST_CR_SEND;
            ST_DEVIL_WAIT:
                if (done || tmo) state_d = ST_CR_SEND;
            ST_CR_SEND:
                if (i_crready)
                    state_d = crresp_q[CRRESP_DT] ? ST_CD_SEND : ST_IDLE;
            ST_CD_SEND:
                if (cd_last_hs) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // State register; acready follows the next state so it drops
    // right after an AC handshake.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            state_q   <= ST_IDLE;
            acready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acready_q <= (state_d == ST_IDLE);
        end
    end

    // Snoop capture, devil result collection and timeout override.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            addr_q   <= '0;
            snoop_q  <= '0;
            crresp_q <= '0;
            rdata_q  <= '0;
            cr_got_q <= 1'b0;
            cd_got_q <= 1'b0;
            timer_q  <= '0;
            beat_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) && i_acvalid && acready_q) begin
                addr_q  <= i_acaddr;
                snoop_q <= i_acsnoop;
            end
            if (in_decode) begin
                crresp_q <= '0;
                rdata_q  <= '0;
                cr_got_q <= 1'b0;
                cd_got_q <= 1'b0;
                timer_q  <= '0;
                beat_q   <= '0;
            end
            if (in_wait) begin
                timer_q <= timer_q + 1'b1;
                if (!cr_got_q && i_devil_crvalid) begin
                    cr_got_q <= 1'b1;
                    crresp_q <= i_devil_crresp;
                end
                if (!cd_got_q && i_devil_cdvalid && i_devil_cdlast) begin
                    cd_got_q <= 1'b1;
                    rdata_q  <= i_devil_rdata;
                end
                if (tmo && !done) begin
                    crresp_q <= '0;
                    rdata_q  <= '0;
                end
            end
            if ((state_q == ST_CD_SEND) && i_cdready)
                beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
    end

    // Devil handshake pulses, saturating hit count, sticky timeout flag.
    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            hit_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            start_q <= in_decode && match;
            ack_q   <= done || tmo;
            if (in_decode && match && (hit_q != '1))
                hit_q <= hit_q + 1'b1;
            if (!i_control_reg[CTRL_EN])
                tflag_q <= 1'b0;
            else if (tmo && !done)
                tflag_q <= 1'b1;
        end
    end

    assign o_acready      = acready_q;
    assign o_devil_start  = start_q;
    assign o_devil_ack    = ack_q;
    assign o_crvalid      = (state_q == ST_CR_SEND);
    assign o_crresp       = o_crvalid ? crresp_q : '0;
    assign o_cdvalid      = (state_q == ST_CD_SEND);
    assign o_cddata       = o_cdvalid ? rdata_q : '0;
    assign o_cdlast       = o_cdvalid && (beat_q == LAST_BEAT);
    assign o_state        = state_q;
    assign o_hit_count    = hit_q;
    assign o_timeout_flag = tflag_q;

endmodule

// File: doc/devil_snoop_scheduler.md
Name: devil_snoop_scheduler

Overview:
- Front end of the ACE snoop (AC/CR/CD) channels for the backstabber IP.
- Accepts each snoop request and classifies it against the acsnoop and address-window filters.
- Matched snoops trigger the devil response FSM, collect its CR/CD result, and drive it onto the interconnect handshakes. Unmatched snoops get an immediate benign response (miss, no data).
- Also applies a timeout and keeps hit/timeout statistics for software.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of config/status registers
- C_ACE_ADDR_WIDTH, 44, ACE snoop address width
- C_ACE_DATA_WIDTH, 128, CD data width
- C_CD_BEATS, 4, CD beats per snoop (64B line / 16B)

Ports:
- ace_aclk  in  1  clock
- ace_aresetn  in  1  asynchronous active-low reset
- i_acvalid  in  1  snoop address valid
- o_acready  out  1  snoop address ready
- i_acaddr  in  C_ACE_ADDR_WIDTH  snoop address
- i_acsnoop  in  4  snoop type
- i_control_reg  in  32  bit0 en, bit14 acf_lt (acsnoop filter), bit15 addr_flt
- i_acsnoop_reg  in  32  [3:0] acsnoop value to match
- i_base_addr_reg  in  32  window base, zero-extended
- i_addr_size_reg  in  32  window size in bytes; 0 = empty window
- i_timeout_reg  in  32  devil response timeout, cycles; 0 = no timeout
- o_devil_start  out  1  one-cycle trigger to the devil FSM
- o_devil_ack  out  1  one-cycle pulse; devil clears its valids
- i_devil_crvalid  in  1  devil CR result valid (level)
- i_devil_crresp  in  5  devil CR response
- i_devil_cdvalid  in  1  devil CD data valid (level)
- i_devil_cdlast  in  1  devil CD last (level)
- i_devil_rdata  in  C_ACE_DATA_WIDTH  devil data
- o_crvalid  out  1  CR valid
- o_crresp  out  5  CR response
- i_crready  in  1  CR ready
- o_cdvalid  out  1  CD valid
- o_cddata  out  C_ACE_DATA_WIDTH  CD data
- o_cdlast  out  1  CD last
- i_cdready  in  1  CD ready
- o_state  out  4  FSM state for debug
- o_hit_count  out  32  matched snoops, saturating
- o_timeout_flag  out  1  sticky; set on timeout, cleared when en=0

Behaviour:
Reset:
- All outputs 0; state IDLE; counters 0; flags clear.

IDLE:
- o_acready=1.
- On i_acvalid & o_acready, latch i_acaddr and i_acsnoop; go to DECODE.
- acready drops the cycle after the handshake (one snoop outstanding).

DECODE (1 cycle), match rule:
- en=0 -> no match.
- acf_lt=1 requires acsnoop == i_acsnoop_reg[3:0].
- addr_flt=1 requires base <= acaddr < base+size. The sum is computed at C_ACE_ADDR_WIDTH+1 bits, so it never wraps.
- en=1 with both filters clear -> every snoop matches.

DECODE transitions:
- Match: pulse o_devil_start, increment o_hit_count (saturating at all-ones), clear timer, go to DEVIL_WAIT.
- No match: load crresp=5'b0, no data, go to CR_SEND.

DEVIL_WAIT:
- Latch crresp when i_devil_crvalid=1.
- Latch rdata when i_devil_cdvalid & i_devil_cdlast are both 1.
- Exit when CR is latched and either crresp[0] (DataTransfer)=0 or CD is latched. On exit, pulse o_devil_ack and go to CR_SEND.
- Timer increments each cycle. If i_timeout_reg!=0 and timer == i_timeout_reg, set o_timeout_flag, pulse o_devil_ack, and force crresp=0 / no data -> CR_SEND.
- If exit and timeout coincide in the same cycle, devil data wins.

CR_SEND:
- o_crvalid=1 with o_crresp stable; hold until i_crready.
- Handshake -> CD_SEND if crresp[0]=1, else back to IDLE.

CD_SEND:
- Emit C_CD_BEATS beats, all carrying the latched rdata.
- Beat counter advances only on o_cdvalid & i_cdready.
- o_cdlast=1 on the final beat only.
- Final-beat handshake -> IDLE.

Stability and config:
- Valid, once asserted, stays high and payload stays stable until the handshake completes.
- Config register changes are sampled only in DECODE. The timeout register is read live.

Reset mid-operation:
- Asynchronous return to IDLE; all valids drop immediately; o_hit_count cleared.

Decomposition:
- Shared package backstabber_pkg holds: state encoding (IDLE=0, DECODE=1, DEVIL_WAIT=2, CR_SEND=3, CD_SEND=4), control-register bit indices (EN=0, ACF_LT=14, ADDR_FLT=15), and CRRESP bit positions (DataTransfer=0).
- One natural sub-module, devil_snoop_filter: the combinational/registered match logic for acsnoop compare plus address window, reusable by other snoop monitors.

Test Plan:
- en=0, ACReadShared at 0x1000 -> one CR with crresp=0 two cycles after the AC handshake; no CD; o_devil_start never pulses.
- en=1, addr_flt=1, base=0x1000, size=0x100; snoops at 0x10FF and 0x1100 -> only 0x10FF pulses o_devil_start; o_hit_count=1.
- Matched snoop; devil returns crresp=5'b00001 and rdata=0xDEAD; cdready low for 5 cycles -> CR first, then 4 CD beats of 0xDEAD with cdlast on beat 4; payload stable while stalled.
- acf_lt=1, i_acsnoop_reg=4'h9 (CleanInvalid); snoop acsnoop=4'h9, then 4'h1 -> first matches, second gets the default miss response.
- i_timeout_reg=20; devil never responds -> at 20 cycles o_timeout_flag=1, o_devil_ack pulses, CR crresp=0; flag clears after en is written 0.
- Assert ace_aresetn low during CD_SEND beat 2 -> o_cdvalid and o_crvalid are 0 in the same cycle, state=IDLE, o_acready=1 after release.
